// File: rtl/dallanma_ongorucu.sv
`default_nettype none
// ============================================================================
// Module   : dallanma_ongorucu
// Purpose  : Branch predictor for the RV32 fetch stage. A direct-mapped
//            branch target buffer (BTB) supplies hit/target information and
//            a pattern history table (PHT) of 2-bit saturating counters
//            supplies the taken/not-taken direction for conditional branches.
//            Prediction is combinational from registered state (0-cycle
//            latency); training comes from the execute-stage resolution port
//            and becomes visible on the following cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   DALLANMA_GSHARE_EN  defined   -> PHT index = BTB index XOR zero-extended
//                                    global history register (gshare)
//                       undefined -> PHT index = BTB index (bimodal), no GHR
// ----------------------------------------------------------------------------
// Parameters:
//   BTB_SATIR  BTB/PHT entry count, power of two >= 4 (IDX = log2(BTB_SATIR))
//   GHR_BIT    global history length, 1 <= GHR_BIT <= IDX
// Ports:
//   clk_i                   in   1   clock
//   rst_ni                  in   1   asynchronous active-low reset
//   ps_i                    in  32   fetch PC to predict
//   ps_gecerli_i            in   1   fetch PC valid this cycle
//   tahmin_atla_o           out  1   predicted taken
//   tahmin_hedef_o          out 32   predicted target, 0 on a miss
//   guncelle_gecerli_i      in   1   resolution valid
//   guncelle_ps_i           in  32   PC of the resolved instruction
//   guncelle_buyruk_tipi_i  in   2   JTIP / BTIP / other
//   guncelle_atladi_i       in   1   instruction actually jumped/branched
//   guncelle_hedef_i        in  32   actual target address
// ============================================================================
module dallanma_ongorucu #(
  parameter int BTB_SATIR = 32,
  parameter int GHR_BIT   = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] ps_i,
  input  logic        ps_gecerli_i,
  output logic        tahmin_atla_o,
  output logic [31:0] tahmin_hedef_o,
  input  logic        guncelle_gecerli_i,
  input  logic [31:0] guncelle_ps_i,
  input  logic [1:0]  guncelle_buyruk_tipi_i,
  input  logic        guncelle_atladi_i,
  input  logic [31:0] guncelle_hedef_i
);

  localparam int IDX      = $clog2(BTB_SATIR);
  localparam int ETIKET_W = 31 - IDX;

  // Instruction type encodings shared with the decode/execute stages.
  localparam logic [1:0] c_JTIP = 2'b01;
  localparam logic [1:0] c_BTIP = 2'b10;

  // Counter reset value: weakly not-taken.
  localparam logic [1:0] c_SAYAC_ILK   = 2'b01;
  // Counter value given to a freshly allocated branch: weakly taken.
  localparam logic [1:0] c_SAYAC_TAHSIS = 2'b10;
  localparam logic [1:0] c_SAYAC_MAKS  = 2'b11;
  localparam logic [1:0] c_SAYAC_MIN   = 2'b00;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [BTB_SATIR-1:0] r_gecerli;
  logic [ETIKET_W-1:0]  r_etiket [BTB_SATIR];
  logic [31:0]          r_hedef  [BTB_SATIR];
  logic [BTB_SATIR-1:0] r_jtip;
  logic [1:0]           r_sayac  [BTB_SATIR];

  // History folded into the PHT index; all-zero in the bimodal build.
  logic [IDX-1:0] w_ghr_genis;

  // --------------------------------------------------------------------------
  // Query-side address split
  // --------------------------------------------------------------------------
  // Bit 0 is never part of the index so compressed (halfword) PCs map cleanly.
  logic [IDX-1:0]      w_q_idx;
  logic [ETIKET_W-1:0] w_q_etiket;
  logic [IDX-1:0]      w_q_pidx;
  logic                w_q_isabet;

  assign w_q_idx    = ps_i[IDX:1];
  assign w_q_etiket = ps_i[31:IDX+1];
  assign w_q_pidx   = w_q_idx ^ w_ghr_genis;

  assign w_q_isabet = ps_gecerli_i
                    && r_gecerli[w_q_idx]
                    && (r_etiket[w_q_idx] == w_q_etiket);

  // Unconditional jumps are always taken on a hit; branches follow the
  // counter's MSB.
  assign tahmin_atla_o  = w_q_isabet && (r_jtip[w_q_idx] || r_sayac[w_q_pidx][1]);
  assign tahmin_hedef_o = w_q_isabet ? r_hedef[w_q_idx] : 32'h0;

  // --------------------------------------------------------------------------
  // Update-side decode
  // --------------------------------------------------------------------------
  logic [IDX-1:0]      w_g_idx;
  logic [ETIKET_W-1:0] w_g_etiket;
  logic [IDX-1:0]      w_g_pidx;
  logic                w_g_isabet;
  logic                w_g_jtip;
  logic                w_g_btip;
  logic                w_g_aktif;
  logic                w_btb_yaz;
  logic                w_tahsis;
  logic                w_pht_yaz;
  logic [1:0]          w_sayac_eski;
  logic [1:0]          w_sayac_yeni;

  assign w_g_idx    = guncelle_ps_i[IDX:1];
  assign w_g_etiket = guncelle_ps_i[31:IDX+1];
  assign w_g_pidx   = w_g_idx ^ w_ghr_genis;

  assign w_g_isabet = r_gecerli[w_g_idx] && (r_etiket[w_g_idx] == w_g_etiket);

  assign w_g_jtip  = (guncelle_buyruk_tipi_i == c_JTIP);
  assign w_g_btip  = (guncelle_buyruk_tipi_i == c_BTIP);
  assign w_g_aktif = guncelle_gecerli_i && (w_g_jtip || w_g_btip);

  // Only taken control transfers touch the BTB: a hit refreshes target and
  // type (covers a jalr whose target moved), a miss allocates over whatever
  // occupied the slot. Not-taken resolutions never allocate.
  assign w_btb_yaz = w_g_aktif && guncelle_atladi_i;
  assign w_tahsis  = w_btb_yaz && !w_g_isabet;

  // Conditional branches train the PHT even when they miss in the BTB.
  assign w_pht_yaz = guncelle_gecerli_i && w_g_btip;

  assign w_sayac_eski = r_sayac[w_g_pidx];

  always_comb begin : p_sayac_sonraki
    w_sayac_yeni = w_sayac_eski;
    if (w_tahsis) begin
      w_sayac_yeni = c_SAYAC_TAHSIS;
    end else if (guncelle_atladi_i) begin
      if (w_sayac_eski != c_SAYAC_MAKS) begin
        w_sayac_yeni = w_sayac_eski + 2'd1;
      end
    end else begin
      if (w_sayac_eski != c_SAYAC_MIN) begin
        w_sayac_yeni = w_sayac_eski - 2'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Global history (gshare build only)
  // --------------------------------------------------------------------------
`ifdef DALLANMA_GSHARE_EN
  logic [GHR_BIT-1:0] r_ghr;
  logic [GHR_BIT-1:0] w_ghr_sonraki;

  generate
    if (GHR_BIT == 1) begin : g_ghr_tek
      assign w_ghr_sonraki = guncelle_atladi_i;
    end else begin : g_ghr_cok
      assign w_ghr_sonraki = {r_ghr[GHR_BIT-2:0], guncelle_atladi_i};
    end
  endgenerate

  // History only advances on resolved conditional branches, never
  // speculatively, so fetch and execute always agree on its value.
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_ghr
    if (!rst_ni) begin
      r_ghr <= '0;
    end else if (w_pht_yaz) begin
      r_ghr <= w_ghr_sonraki;
    end
  end

  always_comb begin : p_ghr_genislet
    w_ghr_genis                = '0;
    w_ghr_genis[GHR_BIT-1:0]   = r_ghr;
  end
`else
  assign w_ghr_genis = '0;
`endif

  // --------------------------------------------------------------------------
  // State with reset: valid bits and direction counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_durum
    if (!rst_ni) begin
      r_gecerli <= '0;
      for (int i = 0; i < BTB_SATIR; i++) begin
        r_sayac[i] <= c_SAYAC_ILK;
      end
    end else begin
      if (w_btb_yaz) begin
        r_gecerli[w_g_idx] <= 1'b1;
      end
      if (w_pht_yaz) begin
        r_sayac[w_g_pidx] <= w_sayac_yeni;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Payload without reset: tag, target, type. These are only ever observed
  // through a set valid bit, so they need no initial value. A write sampled
  // during reset lands here but stays invisible because its valid bit is held
  // clear.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin : p_veri
    if (w_btb_yaz) begin
      r_etiket[w_g_idx] <= w_g_etiket;
      r_hedef[w_g_idx]  <= guncelle_hedef_i;
      r_jtip[w_g_idx]   <= w_g_jtip;
    end
  end

  // Bit 0 of either PC carries no index or tag information.
  logic w_unused_ps_lsb;
  assign w_unused_ps_lsb = ps_i[0] ^ guncelle_ps_i[0];

endmodule
`default_nettype wire

// File: tb/tb_dallanma_ongorucu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dallanma_ongorucu
// Purpose  : Self-checking bench for dallanma_ongorucu. Table-driven vectors
//            (one cycle each) feed a scoreboard queue; the prediction of each
//            cycle is popped and compared at the falling edge. Hand-written
//            sequences cover asynchronous reset and the gshare index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dallanma_ongorucu;

  localparam logic [1:0] T_DIGER  = 2'b00;
  localparam logic [1:0] T_JTIP   = 2'b01;
  localparam logic [1:0] T_BTIP   = 2'b10;
  localparam logic [1:0] T_DIGER3 = 2'b11;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] ps_i = '0;
  logic        ps_gecerli_i = 1'b0;
  logic        tahmin_atla_o;
  logic [31:0] tahmin_hedef_o;
  logic        guncelle_gecerli_i = 1'b0;
  logic [31:0] guncelle_ps_i = '0;
  logic [1:0]  guncelle_buyruk_tipi_i = T_DIGER;
  logic        guncelle_atladi_i = 1'b0;
  logic [31:0] guncelle_hedef_i = '0;

  always #5 clk = ~clk;

  dallanma_ongorucu #(
    .BTB_SATIR(32),
    .GHR_BIT  (5)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .ps_i                  (ps_i),
    .ps_gecerli_i          (ps_gecerli_i),
    .tahmin_atla_o         (tahmin_atla_o),
    .tahmin_hedef_o        (tahmin_hedef_o),
    .guncelle_gecerli_i    (guncelle_gecerli_i),
    .guncelle_ps_i         (guncelle_ps_i),
    .guncelle_buyruk_tipi_i(guncelle_buyruk_tipi_i),
    .guncelle_atladi_i     (guncelle_atladi_i),
    .guncelle_hedef_i      (guncelle_hedef_i)
  );

  typedef struct {
    bit          rst;
    bit          qg;
    logic [31:0] qps;
    bit          ug;
    logic [31:0] ups;
    logic [1:0]  tip;
    bit          atl;
    logic [31:0] hed;
    bit          ea;
    logic [31:0] eh;
  } vec_t;

  typedef struct {
    string       ad;
    logic        ea;
    logic [31:0] eh;
  } beklenen_t;

  vec_t      vecs[$];
  beklenen_t sb[$];
  int        n_vec = 0;
  int        n_err = 0;

  function automatic void add(input bit rst, input bit qg, input logic [31:0] qps,
                              input bit ug, input logic [31:0] ups, input logic [1:0] tip,
                              input bit atl, input logic [31:0] hed,
                              input bit ea, input logic [31:0] eh);
    vec_t v;
    v.rst = rst; v.qg = qg; v.qps = qps;
    v.ug = ug; v.ups = ups; v.tip = tip; v.atl = atl; v.hed = hed;
    v.ea = ea; v.eh = eh;
    vecs.push_back(v);
  endfunction

  task automatic beklenen_ekle(input string ad, input logic ea, input logic [31:0] eh);
    beklenen_t b;
    b.ad = ad; b.ea = ea; b.eh = eh;
    sb.push_back(b);
  endtask

  task automatic kontrol();
    beklenen_t b;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: prediction with no expected entry (atla=%0b hedef=%h)",
               tahmin_atla_o, tahmin_hedef_o);
    end else begin
      b = sb.pop_front();
      if (tahmin_atla_o !== b.ea || tahmin_hedef_o !== b.eh) begin
        n_err++;
        $display("FAIL %s: got atla=%0b hedef=%h, expected atla=%0b hedef=%h",
                 b.ad, tahmin_atla_o, tahmin_hedef_o, b.ea, b.eh);
      end
    end
  endtask

  task automatic sur(input vec_t v);
    ps_gecerli_i           = v.qg;
    ps_i                   = v.qps;
    guncelle_gecerli_i     = v.ug;
    guncelle_ps_i          = v.ups;
    guncelle_buyruk_tipi_i = v.tip;
    guncelle_atladi_i      = v.atl;
    guncelle_hedef_i       = v.hed;
  endtask

  task automatic bosta();
    ps_gecerli_i       = 1'b0;
    guncelle_gecerli_i = 1'b0;
  endtask

  // Each vector occupies one cycle: drive after the rising edge, compare at
  // the falling edge. The vector's update is sampled at the next rising edge.
  task automatic run_all(input string grup);
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      sur(vecs[k]);
      if (vecs[k].rst) rst_ni = 1'b0;
      beklenen_ekle($sformatf("%s[%0d]", grup, k), vecs[k].ea, vecs[k].eh);
      @(negedge clk);
      kontrol();
      if (vecs[k].rst) begin
        #1;
        rst_ni = 1'b1;
      end
    end
    vecs.delete();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Reset state, observed while reset is still held.
    ps_i = 32'h100;
    ps_gecerli_i = 1'b1;
    repeat (2) @(posedge clk);
    beklenen_ekle("reset_state", 1'b0, 32'h0);
    @(negedge clk);
    kontrol();
    #1 rst_ni = 1'b1;

    // Jump allocation, tag mismatch, valid gating, same-cycle query/update,
    // ignored types, full-width tag compare.
    add(1, 1, 32'h100,       0, 32'h0,         T_DIGER,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h100,       1, 32'h100,       T_JTIP,   1, 32'h200,       0, 32'h0);
    add(0, 1, 32'h100,       0, 32'h0,         T_DIGER,  0, 32'h0,         1, 32'h200);
    add(0, 1, 32'h140,       0, 32'h0,         T_DIGER,  0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h100,       0, 32'h0,         T_DIGER,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h100,       1, 32'h100,       T_JTIP,   1, 32'h400,       1, 32'h200);
    add(0, 1, 32'h100,       1, 32'h100,       T_DIGER,  1, 32'h500,       1, 32'h400);
    add(0, 1, 32'h100,       1, 32'h100,       T_DIGER3, 1, 32'h500,       1, 32'h400);
    add(0, 1, 32'h100,       0, 32'h100,       T_JTIP,   1, 32'h600,       1, 32'h400);
    add(0, 1, 32'h100,       1, 32'h8000_0100, T_JTIP,   1, 32'h1234_5678, 1, 32'h400);
    add(0, 1, 32'h8000_0100, 0, 32'h0,         T_DIGER,  0, 32'h0,         1, 32'h1234_5678);
    add(0, 1, 32'h100,       0, 32'h0,         T_DIGER,  0, 32'h0,         0, 32'h0);
    run_all("jal");

`ifndef DALLANMA_GSHARE_EN
    // Bimodal branch training and counter saturation at both ends.
    add(1, 1, 32'h8000_0100, 0, 32'h0,  T_DIGER, 0, 32'h0,  0, 32'h0);
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 0, 32'h0);   // alloc -> 10
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h40, 1, 32'h40);  // 10 -> 01
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h40, 0, 32'h40);  // 01 -> 00
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 0, 32'h40);  // 00 -> 01
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 0, 32'h40);  // 01 -> 10
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 1, 32'h40);  // 10 -> 11
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 1, 32'h40);  // 11 stays
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 1, 32'h40);
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 1, 32'h40);
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 1, 32'h40);
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h40, 1, 32'h40);  // 11 -> 10
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h40, 1, 32'h40);  // 10 -> 01
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h40, 0, 32'h40);  // 01 -> 00
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h40, 0, 32'h40);  // 00 stays
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h40, 0, 32'h40);  // 00 -> 01
    add(0, 1, 32'h80, 1, 32'h80, T_JTIP, 1, 32'h44, 0, 32'h40);  // jtip=1, PHT untouched
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 0, 32'h48, 1, 32'h44);  // no BTB write, 01 -> 00
    add(0, 1, 32'h80, 1, 32'h80, T_BTIP, 1, 32'h48, 1, 32'h44);  // jtip=0, 00 -> 01
    add(0, 1, 32'h80, 0, 32'h0,  T_DIGER, 0, 32'h0, 0, 32'h48);
    run_all("btip");

    // Not-taken miss does not allocate; eviction; independent indices.
    add(1, 1, 32'h80,  0, 32'h0,   T_DIGER, 0, 32'h0,   0, 32'h0);
    add(0, 1, 32'h300, 1, 32'h300, T_BTIP,  0, 32'h340, 0, 32'h0);
    add(0, 1, 32'h300, 1, 32'h300, T_BTIP,  1, 32'h340, 0, 32'h0);
    add(0, 1, 32'h300, 1, 32'h100, T_JTIP,  1, 32'h200, 1, 32'h340);
    add(0, 1, 32'h300, 1, 32'h104, T_BTIP,  1, 32'h80,  0, 32'h0);
    add(0, 1, 32'h100, 1, 32'h102, T_BTIP,  1, 32'h10,  1, 32'h200);
    add(0, 1, 32'h104, 0, 32'h0,   T_DIGER, 0, 32'h0,   1, 32'h80);
    add(0, 1, 32'h102, 0, 32'h0,   T_DIGER, 0, 32'h0,   1, 32'h10);
    add(0, 1, 32'h100, 0, 32'h0,   T_DIGER, 0, 32'h0,   1, 32'h200);
    run_all("miss");
`else
    // gshare: ghr=00001 after the first taken branch, so the branch at 0x80
    // (idx 0) trains PHT entry 1. History is then walked back to 00001
    // through not-taken resolutions at 0x10C (idx 6) before querying.
    add(1, 1, 32'h80, 0, 32'h0,   T_DIGER, 0, 32'h0,  0, 32'h0);
    add(0, 1, 32'h80, 1, 32'h104, T_BTIP,  1, 32'h10, 0, 32'h0);   // pht2=10, ghr=00001
    add(0, 1, 32'h80, 1, 32'h80,  T_BTIP,  1, 32'h40, 0, 32'h0);   // pht1=10, ghr=00011
    add(0, 1, 32'h80, 1, 32'h10C, T_BTIP,  0, 32'h0,  0, 32'h40);  // ghr=00110
    add(0, 1, 32'h80, 1, 32'h10C, T_BTIP,  0, 32'h0,  0, 32'h40);  // pht0=00, ghr=01100
    add(0, 1, 32'h80, 1, 32'h10C, T_BTIP,  0, 32'h0,  0, 32'h40);  // ghr=11000
    add(0, 1, 32'h80, 1, 32'h10C, T_BTIP,  0, 32'h0,  0, 32'h40);  // ghr=10000
    add(0, 1, 32'h80, 1, 32'h10C, T_BTIP,  1, 32'h20, 0, 32'h40);  // ghr=00001
    add(0, 1, 32'h80,  0, 32'h0, T_DIGER, 0, 32'h0, 1, 32'h40);    // pidx 1 -> 10
    add(0, 1, 32'h104, 0, 32'h0, T_DIGER, 0, 32'h0, 0, 32'h10);    // pidx 3 -> 01
    add(0, 1, 32'h10C, 0, 32'h0, T_DIGER, 0, 32'h0, 0, 32'h20);    // pidx 7 -> 01
    run_all("gshare");
`endif

    // Asynchronous reset asserted mid-cycle clears predictions at once; an
    // update sampled while reset is low is lost; updates after release work.
    @(posedge clk);
    #1;
    bosta();
    guncelle_gecerli_i = 1'b1; guncelle_ps_i = 32'h100;
    guncelle_buyruk_tipi_i = T_JTIP; guncelle_atladi_i = 1'b1; guncelle_hedef_i = 32'h200;
    @(posedge clk);
    #1;
    guncelle_gecerli_i = 1'b0;
    ps_gecerli_i = 1'b1; ps_i = 32'h100;
    beklenen_ekle("arst_before", 1'b1, 32'h200);
    @(negedge clk);
    kontrol();
    #2 rst_ni = 1'b0;
    beklenen_ekle("arst_immediate", 1'b0, 32'h0);
    #1 kontrol();
    guncelle_gecerli_i = 1'b1; guncelle_hedef_i = 32'h300;
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    guncelle_gecerli_i = 1'b0;
    beklenen_ekle("arst_after_release", 1'b0, 32'h0);
    @(negedge clk);
    kontrol();
    @(posedge clk);
    #1;
    guncelle_gecerli_i = 1'b1;
    beklenen_ekle("arst_update_lost", 1'b0, 32'h0);
    @(negedge clk);
    kontrol();
    @(posedge clk);
    #1;
    guncelle_gecerli_i = 1'b0;
    beklenen_ekle("post_reset_update", 1'b1, 32'h300);
    @(negedge clk);
    kontrol();

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
